// File: rtl/branch_pkg.sv
// branch_pkg: shared definitions for the branch redirect unit.
//   - br_type encodings (BEQ/BNE/JAL/reserved)
//   - redirect FSM state type
//   - PC_STEP, the sequential fetch increment
package branch_pkg;

  localparam logic [1:0] BR_BEQ = 2'b00;
  localparam logic [1:0] BR_BNE = 2'b01;
  localparam logic [1:0] BR_JAL = 2'b10;
  localparam logic [1:0] BR_RSV = 2'b11;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/branch_decide.sv
// branch_decide: combinational taken decision for a control-transfer
// instruction in execute.
//   br_valid : instruction present this cycle
//   br_type  : 00 BEQ, 01 BNE, 10 JAL, 11 reserved
//   br_res   : comparator result, 1 = operands differ
//   taken    : redirect required (only ever 1 when br_valid is 1)
module branch_decide
  import branch_pkg::*;
(
  input  logic       br_valid,
  input  logic [1:0] br_type,
  input  logic       br_res,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    if (br_valid) begin
      case (br_type)
        BR_BEQ:  taken = ~br_res;
        BR_BNE:  taken = br_res;
        BR_JAL:  taken = 1'b1;
        default: taken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/branch_redirect.sv
// branch_redirect: fetch PC generator with branch redirect and post-branch
// flush window.
//   Parameters: RESET_PC     - PC loaded on reset
//               FLUSH_CYCLES - flush cycles after a taken branch (1..3)
//   Ports: clk, rst (sync, active-high), stall (hold sequential advance),
//          br_valid/br_type/br_res/br_target (branch in execute),
//          pc (fetch PC), flush (kill younger instrs), misalign (one-cycle
//          pulse after a taken branch whose target had low bits set).
//   Optional: define BRANCH_STATS_EN to add br_total_cnt / br_taken_cnt,
//          saturating counters of branches accepted in RUN and taken ones.
module branch_redirect
  import branch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [1:0]  br_type,
  input  logic        br_res,
  input  logic [31:0] br_target,
  output logic [31:0] pc,
  output logic        flush,
`ifdef BRANCH_STATS_EN
  output logic        misalign,
  output logic [31:0] br_total_cnt,
  output logic [31:0] br_taken_cnt
`else
  output logic        misalign
`endif
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        mis_q, mis_d;
  logic        taken;

  branch_decide u_decide (
    .br_valid (br_valid),
    .br_type  (br_type),
    .br_res   (br_res),
    .taken    (taken)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    mis_d   = 1'b0;
    case (state_q)
      ST_RUN: begin
        // A taken redirect wins over stall.
        if (taken) begin
          pc_d    = {br_target[31:2], 2'b00};
          state_d = ST_FLUSH;
          cnt_d   = 2'(FLUSH_CYCLES);
          mis_d   = |br_target[1:0];
        end else if (!stall) begin
          pc_d = pc_q + PC_STEP;
        end
      end
      ST_FLUSH: begin
        // Branches are ignored here; the window length is fixed, so the
        // count runs down even while fetch is stalled.
        if (!stall) begin
          pc_d = pc_q + PC_STEP;
        end
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign pc       = pc_q;
  assign flush    = (state_q == ST_FLUSH);
  assign misalign = mis_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] total_q;
  logic [31:0] taken_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      total_q <= '0;
      taken_q <= '0;
    end else if (state_q == ST_RUN) begin
      if (br_valid && (total_q != '1)) begin
        total_q <= total_q + 32'd1;
      end
      if (taken && (taken_q != '1)) begin
        taken_q <= taken_q + 32'd1;
      end
    end
  end

  assign br_total_cnt = total_q;
  assign br_taken_cnt = taken_q;
`endif

endmodule

// File: tb/tb_branch_redirect.sv
module tb_branch_redirect;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        br_valid = 1'b0;
  logic [1:0]  br_type = 2'b00;
  logic        br_res = 1'b0;
  logic [31:0] br_target = '0;
  logic [31:0] pc;
  logic        flush;
  logic        misalign;
`ifdef BRANCH_STATS_EN
  logic [31:0] br_total_cnt;
  logic [31:0] br_taken_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct {
    logic [31:0] pc;
    logic        fl;
    logic        mi;
    string       nm;
  } exp_t;

  exp_t expq[$];

  always #5 clk = ~clk;

  branch_redirect #(
    .RESET_PC     (32'h0000_0000),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .br_valid     (br_valid),
    .br_type      (br_type),
    .br_res       (br_res),
    .br_target    (br_target),
    .pc           (pc),
    .flush        (flush),
`ifdef BRANCH_STATS_EN
    .misalign     (misalign),
    .br_total_cnt (br_total_cnt),
    .br_taken_cnt (br_taken_cnt)
`else
    .misalign     (misalign)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge and queue the state
  // expected after the following rising edge.
  task automatic step(input logic r, input logic s, input logic bv,
                      input logic [1:0] bt, input logic rs, input logic [31:0] tg,
                      input logic [31:0] epc, input logic efl, input logic emi,
                      input string nm);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s; br_valid = bv; br_type = bt; br_res = rs; br_target = tg;
    e.pc = epc; e.fl = efl; e.mi = emi; e.nm = nm;
    expq.push_back(e);
  endtask

  // Monitor: state is presented every cycle, sampled 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk({e.nm, ".pc"}, pc, e.pc);
        chk({e.nm, ".flush"}, {31'd0, flush}, {31'd0, e.fl});
        chk({e.nm, ".misalign"}, {31'd0, misalign}, {31'd0, e.mi});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //    rst  stl  bv  type   res  target          pc              fl   mi
    step(1'b1,1'b0,1'b0,2'b00,1'b0,32'h0,          32'h0000_0000,1'b0,1'b0,"reset");
    step(1'b0,1'b0,1'b0,2'b00,1'b0,32'h0,          32'h0000_0004,1'b0,1'b0,"seq1");
    step(1'b0,1'b0,1'b0,2'b00,1'b0,32'h0,          32'h0000_0008,1'b0,1'b0,"seq2");
    step(1'b0,1'b0,1'b0,2'b00,1'b0,32'h0,          32'h0000_000C,1'b0,1'b0,"seq3");
    step(1'b0,1'b1,1'b0,2'b00,1'b0,32'h0,          32'h0000_000C,1'b0,1'b0,"stall_hold");
    step(1'b0,1'b0,1'b1,2'b00,1'b1,32'h500,        32'h0000_0010,1'b0,1'b0,"beq_nt");
    step(1'b0,1'b0,1'b1,2'b00,1'b0,32'h100,        32'h0000_0100,1'b1,1'b0,"beq_t");
    step(1'b0,1'b0,1'b0,2'b00,1'b0,32'h0,          32'h0000_0104,1'b1,1'b0,"beq_fl2");
    step(1'b0,1'b0,1'b0,2'b00,1'b0,32'h0,          32'h0000_0108,1'b0,1'b0,"beq_run");
    step(1'b0,1'b0,1'b1,2'b01,1'b0,32'h700,        32'h0000_010C,1'b0,1'b0,"bne_nt");
    step(1'b0,1'b1,1'b1,2'b01,1'b1,32'h40,         32'h0000_0040,1'b1,1'b0,"bne_t_stall");
    step(1'b0,1'b1,1'b0,2'b00,1'b0,32'h0,          32'h0000_0040,1'b1,1'b0,"fl_stall");
    step(1'b0,1'b0,1'b0,2'b00,1'b0,32'h0,          32'h0000_0044,1'b0,1'b0,"fl_end");
    step(1'b0,1'b0,1'b1,2'b10,1'b0,32'h203,        32'h0000_0200,1'b1,1'b1,"jal_mis");
    step(1'b0,1'b0,1'b1,2'b10,1'b0,32'h800,        32'h0000_0204,1'b1,1'b0,"fl_ign1");
    step(1'b0,1'b0,1'b1,2'b00,1'b0,32'h900,        32'h0000_0208,1'b0,1'b0,"fl_ign2");
    step(1'b0,1'b0,1'b1,2'b11,1'b0,32'h300,        32'h0000_020C,1'b0,1'b0,"rsv_nt");
    step(1'b0,1'b0,1'b0,2'b00,1'b0,32'h600,        32'h0000_0210,1'b0,1'b0,"no_valid");
    step(1'b0,1'b0,1'b1,2'b01,1'b1,32'h1001,       32'h0000_1000,1'b1,1'b1,"bne_mis");
    step(1'b0,1'b0,1'b0,2'b00,1'b0,32'h0,          32'h0000_1004,1'b1,1'b0,"mis_fl2");
    step(1'b1,1'b0,1'b1,2'b10,1'b0,32'h88,         32'h0000_0000,1'b0,1'b0,"rst_in_flush");
    step(1'b0,1'b0,1'b0,2'b00,1'b0,32'h0,          32'h0000_0004,1'b0,1'b0,"after_rst");
    step(1'b0,1'b0,1'b1,2'b10,1'b0,32'hFFFF_FFFE,  32'hFFFF_FFFC,1'b1,1'b1,"jal_top");
    step(1'b0,1'b1,1'b0,2'b00,1'b0,32'h0,          32'hFFFF_FFFC,1'b1,1'b0,"top_stall1");
    step(1'b0,1'b1,1'b0,2'b00,1'b0,32'h0,          32'hFFFF_FFFC,1'b0,1'b0,"top_stall2");
    step(1'b0,1'b0,1'b0,2'b00,1'b0,32'h0,          32'h0000_0000,1'b0,1'b0,"wrap");
    step(1'b0,1'b1,1'b1,2'b10,1'b0,32'h10,         32'h0000_0010,1'b1,1'b0,"jal_stall");
    step(1'b0,1'b0,1'b0,2'b00,1'b0,32'h0,          32'h0000_0014,1'b1,1'b0,"js_fl2");
    step(1'b0,1'b0,1'b0,2'b00,1'b0,32'h0,          32'h0000_0018,1'b0,1'b0,"js_run");
    step(1'b1,1'b0,1'b1,2'b10,1'b0,32'h45,         32'h0000_0000,1'b0,1'b0,"rst_vs_br");
    step(1'b0,1'b0,1'b0,2'b00,1'b0,32'h0,          32'h0000_0004,1'b0,1'b0,"rst_run");
`ifdef BRANCH_STATS_EN
    step(1'b0,1'b0,1'b1,2'b00,1'b1,32'h50,         32'h0000_0008,1'b0,1'b0,"st_beq_nt");
    step(1'b0,1'b0,1'b1,2'b01,1'b0,32'h50,         32'h0000_000C,1'b0,1'b0,"st_bne_nt");
    step(1'b0,1'b0,1'b1,2'b11,1'b1,32'h50,         32'h0000_0010,1'b0,1'b0,"st_rsv");
    step(1'b0,1'b0,1'b1,2'b10,1'b0,32'h80,         32'h0000_0080,1'b1,1'b0,"st_jal");
    step(1'b0,1'b0,1'b1,2'b10,1'b0,32'h90,         32'h0000_0084,1'b1,1'b0,"st_fl1");
    step(1'b0,1'b0,1'b0,2'b00,1'b0,32'h0,          32'h0000_0088,1'b0,1'b0,"st_fl2");
    step(1'b0,1'b0,1'b1,2'b00,1'b0,32'hA0,         32'h0000_00A0,1'b1,1'b0,"st_beq_t");
    step(1'b0,1'b0,1'b0,2'b00,1'b0,32'h0,          32'h0000_00A4,1'b1,1'b0,"st_fl3");
    step(1'b0,1'b0,1'b0,2'b00,1'b0,32'h0,          32'h0000_00A8,1'b0,1'b0,"st_fl4");
    @(negedge clk);
    chk("stats.total", br_total_cnt, 32'd5);
    chk("stats.taken", br_taken_cnt, 32'd2);
    force dut.total_q = '1;
    force dut.taken_q = '1;
    #1;
    release dut.total_q;
    release dut.taken_q;
    step(1'b0,1'b0,1'b1,2'b10,1'b0,32'hC0,         32'h0000_00C0,1'b1,1'b0,"st_sat");
    @(negedge clk);
    chk("stats.total_sat", br_total_cnt, 32'hFFFF_FFFF);
    chk("stats.taken_sat", br_taken_cnt, 32'hFFFF_FFFF);
`endif
    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
